// File: rtl/hw_pkg.sv
// Shared types and helpers for the iterative Hamming-weight engine.
package hw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cw(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/hw_chunk.sv
// Combinational popcount of an N-bit vector.
module hw_chunk #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]             v,
  output logic [$clog2(N+1)-1:0]   cnt
);

  localparam int unsigned W = $clog2(N + 1);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt = cnt + W'(v[i]);
    end
  end

endmodule

// File: rtl/hw_iter.sv
// Multi-cycle Hamming-weight engine: popcount(a) or popcount(a^b), CHUNK bits per clock,
// with valid/ready handshakes on both sides.
module hw_iter
  import hw_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned CHUNK = 8,
  localparam int unsigned CW    = cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             all_ones,
  output logic             busy
);

  localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned PW     = $clog2(CHUNK + 1);

  generate
    if (CHUNK == 0 || CHUNK > WIDTH) begin : g_bad_chunk
      $error("hw_iter: CHUNK must satisfy 1 <= CHUNK <= WIDTH");
    end else if (WIDTH % CHUNK != 0) begin : g_bad_div
      $error("hw_iter: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    acc, acc_nxt;
  logic [IW-1:0]    idx;
  logic [PW-1:0]    pc;
  logic             last;

  hw_chunk #(.N(CHUNK)) u_chunk (
    .v   (data_q[CHUNK-1:0]),
    .cnt (pc)
  );

  assign acc_nxt = acc + CW'(pc);
  assign last    = (idx == IW'(NCHUNK - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    all_ones = out_valid && (count == CW'(WIDTH));
  end

  // count is loaded from the final accumulate so it is valid the cycle DONE is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      acc    <= '0;
      idx    <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data_q <= mode ? (a ^ b) : a;
          acc    <= '0;
          idx    <= '0;
        end
        RUN: begin
          acc    <= acc_nxt;
          data_q <= data_q >> CHUNK;
          idx    <= idx + IW'(1);
          if (last) count <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hw_iter.sv
// Directed and randomized bench for hw_iter, including a small parameter sweep.
module tb_hw_iter;
  import hw_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned CW    = cw(WIDTH);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             mode = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready, out_valid, all_ones, busy;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  hw_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .all_ones  (all_ones),
    .busy      (busy)
  );

  // sweep configs: (WIDTH,CHUNK) = (32,1) (32,32) (64,8) (8,4)
  localparam int unsigned SW_W [4] = '{32, 32, 64, 8};
  localparam int unsigned SW_C [4] = '{1, 32, 8, 4};
  localparam int unsigned SW_N [4] = '{32, 1, 8, 2};

  logic        sw_valid = 1'b0;
  logic        sw_oready = 1'b0;
  logic        sw_mode = 1'b0;
  logic [63:0] sw_a = '0;
  logic [63:0] sw_b = '0;
  logic [63:0] hold = '0;
  logic        sw_ir [4];
  logic        sw_ov [4];
  logic        sw_ao [4];
  logic        sw_busy [4];
  logic [6:0]  sw_cnt [4];
  logic [6:0]  sw_ref [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int unsigned W = SW_W[g];
    localparam int unsigned C = SW_C[g];
    logic [cw(W)-1:0]         cnt_g;
    logic [$clog2(W+1)-1:0]   ref_g;
    hw_iter #(.WIDTH(W), .CHUNK(C)) u (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_valid),
      .in_ready  (sw_ir[g]),
      .mode      (sw_mode),
      .a         (sw_a[W-1:0]),
      .b         (sw_b[W-1:0]),
      .out_valid (sw_ov[g]),
      .out_ready (sw_oready),
      .count     (cnt_g),
      .all_ones  (sw_ao[g]),
      .busy      (sw_busy[g])
    );
    hw_chunk #(.N(W)) r (
      .v   (hold[W-1:0]),
      .cnt (ref_g)
    );
    assign sw_cnt[g] = 7'(cnt_g);
    assign sw_ref[g] = 7'(ref_g);
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic m, input logic [31:0] ta, input logic [31:0] tb_v,
                        input bit scramble, output int lat);
    check("in_ready_pre", 64'(in_ready), 64'd1);
    mode = m; a = ta; b = tb_v; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (scramble) begin
      a = ~ta; b = $urandom; mode = ~m;
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    bit seen;
    int swlat [4];
    bit all_done;

    // reset then idle
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_all_ones", 64'(all_ones), 64'd0);

    // popcount, full word
    out_ready = 1'b1;
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, lat);
    check("pc_ff_lat", 64'(lat), 64'd4);
    check("pc_ff_count", 64'(count), 64'd32);
    check("pc_ff_all_ones", 64'(all_ones), 64'd1);
    tick();
    check("pc_ff_retire_valid", 64'(out_valid), 64'd0);
    check("pc_ff_retire_ready", 64'(in_ready), 64'd1);

    run_op(1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0, lat);
    check("pc_81_lat", 64'(lat), 64'd4);
    check("pc_81_count", 64'(count), 64'd2);
    check("pc_81_all_ones", 64'(all_ones), 64'd0);
    tick();

    // hamming distance
    run_op(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, lat);
    check("hd_full_lat", 64'(lat), 64'd4);
    check("hd_full_count", 64'(count), 64'd32);
    check("hd_full_all_ones", 64'(all_ones), 64'd1);
    tick();
    run_op(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, lat);
    check("hd_eq_count", 64'(count), 64'd0);
    tick();
    run_op(1'b1, 32'hF000_000F, 32'h0000_0000, 1'b1, lat);
    check("hd_scramble_lat", 64'(lat), 64'd4);
    check("hd_scramble_count", 64'(count), 64'd8);
    tick();

    // backpressure with an ignored in_valid pulse
    out_ready = 1'b0;
    run_op(1'b0, 32'h0000_00FF, 32'h0, 1'b0, lat);
    check("bp_lat", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1; a = 32'hFFFF_FFFF;
      end
      tick();
      in_valid = 1'b0;
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_count", 64'(count), 64'd8);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_rel_valid", 64'(out_valid), 64'd0);
    check("bp_rel_ready", 64'(in_ready), 64'd1);
    check("bp_rel_count", 64'(count), 64'd8);
    check("bp_rel_busy", 64'(busy), 64'd0);

    // reset during the 2nd RUN cycle
    mode = 1'b0; a = 32'hFFFF_FFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_in_ready", 64'(in_ready), 64'd1);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_count", 64'(count), 64'd0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mr_no_valid", 64'(seen), 64'd0);
    run_op(1'b0, 32'h0000_0001, 32'h0, 1'b0, lat);
    check("mr_new_lat", 64'(lat), 64'd4);
    check("mr_new_count", 64'(count), 64'd1);
    tick();

    // parameter sweep with random operands
    for (int op = 0; op < 250; op++) begin
      repeat ($urandom_range(0, 3)) tick();
      sw_mode = 1'($urandom);
      sw_a = {$urandom, $urandom};
      sw_b = {$urandom, $urandom};
      if (op % 8 == 0) begin sw_mode = 1'b0; sw_a = '1; end
      if (op % 8 == 1) begin sw_mode = 1'b1; sw_b = sw_a; end
      hold = sw_mode ? (sw_a ^ sw_b) : sw_a;
      for (int g = 0; g < 4; g++) check("sw_in_ready", 64'(sw_ir[g]), 64'd1);
      sw_valid = 1'b1;
      tick();
      sw_valid = 1'b0;
      sw_a = {$urandom, $urandom};
      sw_b = {$urandom, $urandom};
      sw_mode = ~sw_mode;
      for (int g = 0; g < 4; g++) swlat[g] = 0;
      for (int k = 1; k <= 40; k++) begin
        tick();
        all_done = 1'b1;
        for (int g = 0; g < 4; g++) begin
          if (sw_ov[g] && swlat[g] == 0) begin
            swlat[g] = k;
            check("sw_count", 64'(sw_cnt[g]), 64'(sw_ref[g]));
            check("sw_all_ones", 64'(sw_ao[g]), 64'(sw_ref[g] == 7'(SW_W[g])));
          end
          if (swlat[g] == 0) all_done = 1'b0;
        end
        if (all_done) break;
      end
      for (int g = 0; g < 4; g++) check("sw_latency", 64'(swlat[g]), 64'(SW_N[g]));
      repeat ($urandom_range(0, 3)) tick();
      sw_oready = 1'b1;
      tick();
      sw_oready = 1'b0;
      for (int g = 0; g < 4; g++) check("sw_retire_busy", 64'(sw_busy[g]), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
